// File: rtl/eig_pkg.sv
// Shared types and constants for the eigenvalue datapath.
// The candidate width is twice the half-width N used by the pair-compare stages.
package eig_pkg;

    localparam int EIG_N = 18;
    localparam int EIG_W = 2 * EIG_N;

    typedef logic signed [EIG_W-1:0] eig_data_t;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } eig_state_e;

endpackage

// File: rtl/eig_max_cmp.sv
// Full-width signed greater-than and select.
// Equal values keep the incumbent, so the earliest index wins a tie.
module eig_max_cmp
    import eig_pkg::*;
#(
    parameter int W = EIG_W
) (
    input  logic signed [W-1:0] cand_i,
    input  logic signed [W-1:0] incumbent_i,
    output logic                gt_o,
    output logic signed [W-1:0] sel_o
);

    assign gt_o  = cand_i > incumbent_i;
    assign sel_o = gt_o ? cand_i : incumbent_i;

endmodule

// File: rtl/eig_max_select.sv
// Collects a frame of COUNT signed candidates and presents the largest one
// together with its arrival position, using valid/ready on both sides.
module eig_max_select
    import eig_pkg::*;
#(
    parameter int N     = 18,
    parameter int COUNT = 4,
    parameter int IDX_W = $clog2(COUNT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_max,
    output logic [IDX_W-1:0]   out_idx
);

    localparam int W = 2 * N;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    eig_state_e              state_q, state_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic signed [W-1:0]     max_q, max_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic                    accept;
    logic                    cand_gt;
    logic signed [W-1:0]     cand_sel;

    eig_max_cmp #(.W(W)) u_cmp (
        .cand_i      ($signed(in_data)),
        .incumbent_i (max_q),
        .gt_o        (cand_gt),
        .sel_o       (cand_sel)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign accept    = in_valid && (state_q == ACC);

    // The first candidate of a frame seeds the running maximum without
    // comparing against whatever the previous frame left behind.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        idx_d   = idx_q;
        if (accept) begin
            if (count_q == '0) begin
                max_d = $signed(in_data);
                idx_d = '0;
            end else begin
                max_d = cand_sel;
                if (cand_gt) begin
                    idx_d = count_q;
                end
            end
            if (count_q == LAST) begin
                count_d = '0;
                state_d = DONE;
            end else begin
                count_d = count_q + IDX_W'(1);
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            count_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_eig_max_select.sv
// Directed checks on a COUNT=4 instance plus a randomised COUNT=3 instance
// compared against a small reference model.
module tb_eig_max_select;
    import eig_pkg::*;

    logic clk;
    logic rst_n;

    logic        inValid, inReady, outValid, outReady;
    logic [35:0] inData, outMax;
    logic [1:0]  outIdx;

    logic        bInValid, bInReady, bOutValid, bOutReady;
    logic [35:0] bInData, bOutMax;
    logic [1:0]  bOutIdx;

    int checks   = 0;
    int failures = 0;
    int cycleCnt = 0;
    int firstAcceptCycle;

    eig_max_select #(.N(18), .COUNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_max   (outMax),
        .out_idx   (outIdx)
    );

    eig_max_select #(.N(18), .COUNT(3)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_data   (bInData),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .out_max   (bOutMax),
        .out_idx   (bOutIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one candidate and returns once the edge that accepts it has passed.
    task automatic applyStimulus(input logic [35:0] value, input bit first);
        int guard;
        inValid = 1'b1;
        inData  = value;
        guard   = 0;
        while (!inReady && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!inReady) checkOutput("in_ready_timeout", 36'd0, 36'd1);
        @(posedge clk);
        if (first) firstAcceptCycle = cycleCnt;
        #1;
    endtask

    task automatic sendFrame(input eig_data_t v0, input eig_data_t v1,
                             input eig_data_t v2, input eig_data_t v3);
        applyStimulus(v0, 1'b1);
        applyStimulus(v1, 1'b0);
        applyStimulus(v2, 1'b0);
        applyStimulus(v3, 1'b0);
    endtask

    task automatic checkResult(input string tag, input eig_data_t expMax, input logic [1:0] expIdx);
        checkOutput({tag, "_valid"}, {35'd0, outValid}, 36'd1);
        checkOutput({tag, "_max"}, outMax, expMax);
        checkOutput({tag, "_idx"}, {34'd0, outIdx}, {34'd0, expIdx});
    endtask

    task automatic finishHandshake();
        outReady = 1'b1;
        inValid  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start0;
        logic signed [35:0] refMax, v;
        logic [1:0] refIdx;
        int guard;

        rst_n = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1;
        bInValid = 1'b0; bInData = '0; bOutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {35'd0, outValid}, 36'd0);
        checkOutput("reset_in_ready", {35'd0, inReady}, 36'd1);
        checkOutput("reset_out_max", outMax, 36'd0);
        checkOutput("reset_out_idx", {34'd0, outIdx}, 36'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, continuous traffic, exact one-cycle out_valid pulse
        sendFrame(36'sd5, -36'sd3, 36'sd12, 36'sd7);
        start0 = firstAcceptCycle;
        checkResult("basic", 36'sd12, 2'd2);
        inData = 36'sd1;
        @(posedge clk);
        #1;
        checkOutput("basic_pulse_low", {35'd0, outValid}, 36'd0);
        checkOutput("basic_ready_back", {35'd0, inReady}, 36'd1);
        sendFrame(36'sd1, 36'sd9, 36'sd9, 36'sd2);
        checkOutput("frame_period", 36'(firstAcceptCycle - start0), 36'd5);
        checkResult("second", 36'sd9, 2'd1);
        finishHandshake();

        sendFrame(-36'sd100, -36'sd100, -36'sd200, -36'sd100);
        checkResult("ties", -36'sd100, 2'd0);
        finishHandshake();

        sendFrame(36'h8_0000_0000, 36'h7_FFFF_FFFF, 36'sd0, 36'hF_FFFF_FFFF);
        checkResult("extremes", 36'h7_FFFF_FFFF, 2'd1);
        finishHandshake();

        sendFrame(36'h0_0003_0000, 36'h0_0000_FFFF, 36'sd0, 36'sd1);
        checkResult("upper_bits", 36'h0_0003_0000, 2'd0);
        finishHandshake();

        // Backpressure: DONE must ignore new candidates
        sendFrame(36'sd20, 36'sd40, 36'sd30, 36'sd10);
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 36'sd999;
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("bp_in_ready", {35'd0, inReady}, 36'd0);
        end
        checkResult("bp_hold", 36'sd40, 2'd1);
        finishHandshake();
        sendFrame(36'sd50, 36'sd1, 36'sd2, 36'sd3);
        checkResult("after_bp", 36'sd50, 2'd0);
        finishHandshake();

        // Reset mid-frame discards the partial frame
        applyStimulus(36'sd100, 1'b1);
        applyStimulus(36'sd200, 1'b0);
        inValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {35'd0, outValid}, 36'd0);
        checkOutput("midrst_in_ready", {35'd0, inReady}, 36'd1);
        checkOutput("midrst_out_max", outMax, 36'd0);
        checkOutput("midrst_out_idx", {34'd0, outIdx}, 36'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(36'sd1, 36'sd2, 36'sd3, 36'sd4);
        checkResult("after_rst", 36'sd4, 2'd3);
        finishHandshake();

        // COUNT=3 instance with random bubbles and random consumer stalls
        for (int f = 0; f < 1000; f++) begin
            refMax = '0;
            refIdx = '0;
            for (int k = 0; k < 3; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    bInValid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 1) == 1) v = 36'($signed($urandom_range(0, 6)) - 3);
                else v = {$urandom_range(0, 15), $urandom};
                if (k == 0 || v > refMax) begin
                    refMax = v;
                    refIdx = 2'(k);
                end
                bInValid = 1'b1;
                bInData  = v;
                guard = 0;
                while (!bInReady && guard < 50) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                if (!bInReady) checkOutput("b_ready_timeout", 36'd0, 36'd1);
                @(posedge clk);
                #1;
            end
            bInValid = 1'b0;
            checkOutput("b_valid", {35'd0, bOutValid}, 36'd1);
            checkOutput("b_max", bOutMax, refMax);
            checkOutput("b_idx", {34'd0, bOutIdx}, {34'd0, refIdx});
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bOutReady = 1'b1;
            @(posedge clk);
            #1;
            bOutReady = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
